// File: rtl/hls_shell_pkg.sv
// Shared types and default widths for the HLS buffer shell.
package hls_shell_pkg;

  localparam int DEF_DATA_WID  = 32;
  localparam int DEF_ADDR_WID  = 7;
  localparam int DEF_DEPTH     = 128;
  localparam int DEF_HADDR_WID = 64;

  typedef enum logic [2:0] {
    IDLE,
    RD_WAIT,
    RD_ACK,
    KERNEL,
    WR_SETUP,
    WR_WAIT,
    WR_ACK,
    FIN
  } state_t;

endpackage

// File: rtl/hls_buffer_shell_if.sv
// Host DMA channels and kernel ap_*/buff_* ports of the HLS buffer shell.
interface hls_buffer_shell_if
  import hls_shell_pkg::*;
#(
  parameter int DATA_WID  = DEF_DATA_WID,
  parameter int ADDR_WID  = DEF_ADDR_WID,
  parameter int HADDR_WID = DEF_HADDR_WID
);
  logic                 read_enable;
  logic [HADDR_WID-1:0] read_addr;
  logic                 read_ready;
  logic [DATA_WID-1:0]  read_data;
  logic                 finish_read;
  logic                 write_enable;
  logic [HADDR_WID-1:0] write_addr;
  logic [DATA_WID-1:0]  write_data;
  logic                 write_ready;
  logic                 finish_write;
  logic                 ap_start;
  logic                 ap_done;
  logic [DATA_WID-1:0]  ap_return;
  logic [ADDR_WID-1:0]  buff_address0, buff_address1;
  logic                 buff_ce0, buff_ce1, buff_we0, buff_we1;
  logic [DATA_WID-1:0]  buff_d0, buff_d1, buff_q0, buff_q1;

  modport master (
    output read_enable, read_addr, finish_read,
    output write_enable, write_addr, write_data, finish_write,
    output ap_start, buff_q0, buff_q1,
    input  read_ready, read_data, write_ready, ap_done, ap_return,
    input  buff_address0, buff_address1, buff_ce0, buff_ce1,
    input  buff_we0, buff_we1, buff_d0, buff_d1
  );

  modport slave (
    input  read_enable, read_addr, finish_read,
    input  write_enable, write_addr, write_data, finish_write,
    input  ap_start, buff_q0, buff_q1,
    output read_ready, read_data, write_ready, ap_done, ap_return,
    output buff_address0, buff_address1, buff_ce0, buff_ce1,
    output buff_we0, buff_we1, buff_d0, buff_d1
  );

endinterface

// File: rtl/dp_buffer.sv
// Dual-port buffer: registered read (old data on same-address write), port 1 wins write collisions.
module dp_buffer #(
  parameter int DATA_WID = 32,
  parameter int ADDR_WID = 7,
  parameter int DEPTH    = 128
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [ADDR_WID-1:0] addr0,
  input  logic                ce0,
  input  logic                we0,
  input  logic [DATA_WID-1:0] d0,
  output logic [DATA_WID-1:0] q0,
  input  logic [ADDR_WID-1:0] addr1,
  input  logic                ce1,
  input  logic                we1,
  input  logic [DATA_WID-1:0] d1,
  output logic [DATA_WID-1:0] q1
);

  logic [DATA_WID-1:0] mem [DEPTH];

  // Port 1 is written last so its value survives a same-address collision.
  always_ff @(posedge clk) begin
    if (ce0 && we0) mem[addr0] <= d0;
    if (ce1 && we1) mem[addr1] <= d1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      q0 <= '0;
      q1 <= '0;
    end else begin
      if (ce0 && !we0) q0 <= mem[addr0];
      if (ce1 && !we1) q1 <= mem[addr1];
    end
  end

endmodule

// File: rtl/hls_buffer_shell.sv
// Restartable DMA shell around an HLS kernel with a dual-port local buffer.
// Define CYCLE_COUNTER_EN to add the kernel_cycles output.
module hls_buffer_shell
  import hls_shell_pkg::*;
#(
  parameter int DATA_WID  = DEF_DATA_WID,
  parameter int ADDR_WID  = DEF_ADDR_WID,
  parameter int DEPTH     = DEF_DEPTH,
  parameter int HADDR_WID = DEF_HADDR_WID
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [HADDR_WID-1:0] read_base,
  input  logic [HADDR_WID-1:0] write_base,
  input  logic [HADDR_WID-1:0] read_stride,
  input  logic [HADDR_WID-1:0] write_stride,
  input  logic [HADDR_WID-1:0] num_read,
  input  logic [HADDR_WID-1:0] num_write,
  output logic                 busy,
  output logic                 done,
  output logic                 error,
  output logic [DATA_WID-1:0]  returnvalue,
`ifdef CYCLE_COUNTER_EN
  output logic [HADDR_WID-1:0] kernel_cycles,
`endif
  hls_buffer_shell_if.master   bus
);

  localparam logic [HADDR_WID-1:0] H_ONE   = {{(HADDR_WID-1){1'b0}}, 1'b1};
  localparam logic [HADDR_WID-1:0] DEPTH_H = HADDR_WID'(DEPTH);

  state_t               state, state_nxt;
  logic [HADDR_WID-1:0] rd_addr_q, wr_addr_q, rd_stride_q, wr_stride_q;
  logic [HADDR_WID-1:0] n_rd_q, n_wr_q, i_q, j_q;
  logic                 ap_start_q, done_q, error_q;
  logic [DATA_WID-1:0]  ret_q, q0, q1;
  logic [ADDR_WID-1:0]  p0_addr;
  logic                 p0_ce, p0_we;
  logic [DATA_WID-1:0]  p0_d;
  logic                 oversize, rd_more, wr_more, k_own, job_go;

  assign oversize = (num_read > DEPTH_H) || (num_write > DEPTH_H);
  assign rd_more  = (i_q + H_ONE) < n_rd_q;
  assign wr_more  = (j_q + H_ONE) < n_wr_q;
  assign k_own    = (state == KERNEL) && !reset;
  assign job_go   = (state == IDLE) && start;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Port 0 belongs to the DMA engine outside KERNEL, to the kernel inside it.
  always_comb begin
    state_nxt         = state;
    busy              = (state != IDLE);
    bus.read_enable   = 1'b0;
    bus.finish_read   = 1'b0;
    bus.write_enable  = 1'b0;
    bus.finish_write  = 1'b0;
    p0_addr           = bus.buff_address0;
    p0_ce             = 1'b0;
    p0_we             = 1'b0;
    p0_d              = bus.buff_d0;
    case (state)
      IDLE: if (start && !oversize) state_nxt = (num_read == '0) ? KERNEL : RD_WAIT;
      RD_WAIT: begin
        bus.read_enable = 1'b1;
        p0_addr         = i_q[ADDR_WID-1:0];
        p0_ce           = bus.read_ready;
        p0_we           = bus.read_ready;
        p0_d            = bus.read_data;
        if (bus.read_ready) state_nxt = RD_ACK;
      end
      RD_ACK: begin
        bus.read_enable = 1'b1;
        bus.finish_read = 1'b1;
        state_nxt       = rd_more ? RD_WAIT : KERNEL;
      end
      KERNEL: begin
        p0_ce = bus.buff_ce0;
        p0_we = bus.buff_we0;
        if (bus.ap_done) state_nxt = (n_wr_q == '0) ? FIN : WR_SETUP;
      end
      WR_SETUP: begin
        bus.write_enable = 1'b1;
        p0_addr          = j_q[ADDR_WID-1:0];
        p0_ce            = 1'b1;
        state_nxt        = WR_WAIT;
      end
      WR_WAIT: begin
        bus.write_enable = 1'b1;
        if (bus.write_ready) state_nxt = WR_ACK;
      end
      WR_ACK: begin
        bus.write_enable = 1'b1;
        bus.finish_write = 1'b1;
        state_nxt        = wr_more ? WR_SETUP : FIN;
      end
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ap_start_q <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      ret_q      <= '0;
      i_q        <= '0;
      j_q        <= '0;
    end else begin
      ap_start_q <= (state != KERNEL) && (state_nxt == KERNEL);
      done_q     <= (state_nxt == FIN) || (job_go && oversize);
      if (job_go) begin
        error_q <= oversize;
        i_q     <= '0;
        j_q     <= '0;
      end
      if (state == RD_ACK) i_q <= i_q + H_ONE;
      if (state == WR_ACK && wr_more) j_q <= j_q + H_ONE;
      if (state == KERNEL && bus.ap_done) ret_q <= bus.ap_return;
    end
  end

  // Job parameters and running host addresses; only meaningful while busy.
  always_ff @(posedge clk) begin
    if (job_go) begin
      rd_addr_q   <= read_base;
      wr_addr_q   <= write_base;
      rd_stride_q <= read_stride;
      wr_stride_q <= write_stride;
      n_rd_q      <= num_read;
      n_wr_q      <= num_write;
    end else begin
      if (state == RD_ACK) rd_addr_q <= rd_addr_q + rd_stride_q;
      if (state == WR_ACK && wr_more) wr_addr_q <= wr_addr_q + wr_stride_q;
    end
  end

`ifdef CYCLE_COUNTER_EN
  logic [HADDR_WID-1:0] cyc_q;
  // Counts every KERNEL cycle including the ap_done cycle, then holds.
  always_ff @(posedge clk) begin
    if (reset)                                            cyc_q <= '0;
    else if (state != KERNEL && state_nxt == KERNEL)      cyc_q <= '0;
    else if (state == KERNEL && cyc_q != '1)              cyc_q <= cyc_q + H_ONE;
  end
  assign kernel_cycles = cyc_q;
`endif

  dp_buffer #(
    .DATA_WID (DATA_WID),
    .ADDR_WID (ADDR_WID),
    .DEPTH    (DEPTH)
  ) u_buf (
    .clk   (clk),
    .reset (reset),
    .addr0 (p0_addr),
    .ce0   (p0_ce && !reset),
    .we0   (p0_we),
    .d0    (p0_d),
    .q0    (q0),
    .addr1 (bus.buff_address1),
    .ce1   (k_own && bus.buff_ce1),
    .we1   (bus.buff_we1),
    .d1    (bus.buff_d1),
    .q1    (q1)
  );

  // write_data follows the registered buffer read issued in WR_SETUP; valid from WR_WAIT.
  assign bus.read_addr  = bus.read_enable  ? rd_addr_q : '0;
  assign bus.write_addr = bus.write_enable ? wr_addr_q : '0;
  assign bus.write_data = bus.write_enable ? q0 : '0;
  assign bus.buff_q0    = q0;
  assign bus.buff_q1    = q1;
  assign bus.ap_start   = ap_start_q;
  assign done           = done_q;
  assign error          = error_q;
  assign returnvalue    = ret_q;

endmodule

// File: tb/tb_hls_buffer_shell.sv
// Directed self-checking bench for hls_buffer_shell (DEPTH=128).
module tb_hls_buffer_shell;

  localparam int DW = 32;
  localparam int AW = 7;
  localparam int HW = 64;
  localparam int DEPTH = 128;

  logic          clk = 1'b0;
  logic          reset, start;
  logic [HW-1:0] read_base, write_base, read_stride, write_stride, num_read, num_write;
  logic          busy, done, error;
  logic [DW-1:0] returnvalue;
`ifdef CYCLE_COUNTER_EN
  logic [HW-1:0] kernel_cycles;
`endif

  hls_buffer_shell_if #(.DATA_WID(DW), .ADDR_WID(AW), .HADDR_WID(HW)) bus ();

  hls_buffer_shell #(.DATA_WID(DW), .ADDR_WID(AW), .DEPTH(DEPTH), .HADDR_WID(HW)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .read_base    (read_base),
    .write_base   (write_base),
    .read_stride  (read_stride),
    .write_stride (write_stride),
    .num_read     (num_read),
    .num_write    (num_write),
    .busy         (busy),
    .done         (done),
    .error        (error),
    .returnvalue  (returnvalue),
`ifdef CYCLE_COUNTER_EN
    .kernel_cycles(kernel_cycles),
`endif
    .bus          (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int n_done = 0, n_frd = 0, n_aps = 0, n_rden = 0, n_wren = 0;

  always @(negedge clk) begin
    if (done === 1'b1) n_done++;
    if (bus.finish_read === 1'b1) n_frd++;
    if (bus.ap_start === 1'b1) n_aps++;
    if (bus.read_enable === 1'b1) n_rden++;
    if (bus.write_enable === 1'b1) n_wren++;
  end

  initial begin
    #300000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  function automatic logic [31:0] hd(input int tag, input int k);
    return (32'(tag) << 24) + 32'(k) * 32'h0000_0103;
  endfunction

  function automatic logic [31:0] exp_wr(input int tag, input int kmode, input int k);
    case (kmode)
      0:       return hd(tag, k) + 32'd1;
      1:       return (k == 5) ? 32'hBB : ((k == 6) ? 32'hCC : hd(tag, k));
      default: return hd(tag, k);
    endcase
  endfunction

  task automatic clear_inputs();
    start = 0; read_base = '0; write_base = '0; read_stride = '0; write_stride = '0;
    num_read = '0; num_write = '0;
    bus.read_ready = 0; bus.read_data = '0; bus.write_ready = 0;
    bus.ap_done = 0; bus.ap_return = '0;
    bus.buff_address0 = '0; bus.buff_address1 = '0;
    bus.buff_ce0 = 0; bus.buff_ce1 = 0; bus.buff_we0 = 0; bus.buff_we1 = 0;
    bus.buff_d0 = '0; bus.buff_d1 = '0;
  endtask

  task automatic do_start(input logic [HW-1:0] rb, wb, rs, ws, nr, nw);
    start = 1; read_base = rb; write_base = wb; read_stride = rs; write_stride = ws;
    num_read = nr; num_write = nw;
    @(negedge clk);
    start = 0;
  endtask

  task automatic do_reads(input int tag, input logic [HW-1:0] rb, rs, input int nr, input int dly);
    for (int k = 0; k < nr; k++) begin
      checks++;
      if (bus.read_enable !== 1'b1 || bus.read_addr !== rb + HW'(k) * rs) begin
        failures++;
        $display("FAIL rd_addr[%0d]: en=%b addr=%h expected en=1 addr=%h", k, bus.read_enable, bus.read_addr, rb + HW'(k) * rs);
      end
      for (int d = 0; d < dly; d++) begin
        @(negedge clk);
        checks++;
        if (bus.read_enable !== 1'b1 || bus.finish_read !== 1'b0) begin
          failures++;
          $display("FAIL rd_hold[%0d]: en=%b finish=%b expected en=1 finish=0", k, bus.read_enable, bus.finish_read);
        end
      end
      bus.read_ready = 1; bus.read_data = hd(tag, k);
      @(negedge clk);
      bus.read_ready = 0; bus.read_data = '0;
      checks++;
      if (bus.finish_read !== 1'b1 || bus.read_enable !== 1'b1) begin
        failures++;
        $display("FAIL rd_ack[%0d]: finish=%b en=%b expected 1 1", k, bus.finish_read, bus.read_enable);
      end
      @(negedge clk);
      checks++;
      if (bus.finish_read !== 1'b0) begin
        failures++;
        $display("FAIL rd_ack_len[%0d]: finish=%b expected 0", k, bus.finish_read);
      end
    end
  endtask

  task automatic run_kernel(input int tag, input int kmode, input int nr, input logic [DW-1:0] ret);
    checks++;
    if (bus.ap_start !== 1'b1 || bus.read_enable !== 1'b0) begin
      failures++;
      $display("FAIL ap_start_on: ap_start=%b rd_en=%b expected 1 0", bus.ap_start, bus.read_enable);
    end
    @(negedge clk);
    checks++;
    if (bus.ap_start !== 1'b0) begin
      failures++;
      $display("FAIL ap_start_pulse: ap_start=%b expected 0", bus.ap_start);
    end
    if (kmode == 0) begin
      for (int a = 0; a < nr; a++) begin
        bus.buff_address0 = AW'(a); bus.buff_ce0 = 1; bus.buff_we0 = 0;
        @(negedge clk);
        checks++;
        if (bus.buff_q0 !== hd(tag, a)) begin
          failures++;
          $display("FAIL k_read[%0d]: q0=%h expected %h", a, bus.buff_q0, hd(tag, a));
        end
        bus.buff_we0 = 1; bus.buff_d0 = hd(tag, a) + 32'd1;
        @(negedge clk);
        bus.buff_ce0 = 0; bus.buff_we0 = 0;
      end
    end else if (kmode == 1) begin
      bus.buff_address0 = 7'd5; bus.buff_ce0 = 1; bus.buff_we0 = 1; bus.buff_d0 = 32'hAA;
      bus.buff_address1 = 7'd5; bus.buff_ce1 = 1; bus.buff_we1 = 1; bus.buff_d1 = 32'hBB;
      @(negedge clk);
      bus.buff_address0 = 7'd6; bus.buff_we0 = 0;
      bus.buff_address1 = 7'd6; bus.buff_d1 = 32'hCC;
      @(negedge clk);
      bus.buff_ce1 = 0; bus.buff_we1 = 0;
      checks++;
      if (bus.buff_q0 !== hd(tag, 6)) begin
        failures++;
        $display("FAIL rd_old_data: q0=%h expected %h", bus.buff_q0, hd(tag, 6));
      end
      bus.buff_address0 = 7'd5;
      @(negedge clk);
      bus.buff_ce0 = 0;
      checks++;
      if (bus.buff_q0 !== 32'hBB) begin
        failures++;
        $display("FAIL collide_q: q0=%h expected 000000bb", bus.buff_q0);
      end
      @(negedge clk);
      checks++;
      if (bus.buff_q0 !== 32'hBB) begin
        failures++;
        $display("FAIL q_hold: q0=%h expected 000000bb", bus.buff_q0);
      end
    end
    bus.ap_done = 1; bus.ap_return = ret;
    @(negedge clk);
    bus.ap_done = 0; bus.ap_return = '0;
    checks++;
    if (returnvalue !== ret) begin
      failures++;
      $display("FAIL returnvalue: got %h expected %h", returnvalue, ret);
    end
  endtask

  task automatic do_writes(input int tag, input int kmode, input logic [HW-1:0] wb, ws, input int nw, input int dly);
    for (int j = 0; j < nw; j++) begin
      checks++;
      if (bus.write_enable !== 1'b1 || bus.write_addr !== wb + HW'(j) * ws) begin
        failures++;
        $display("FAIL wr_addr[%0d]: en=%b addr=%h expected en=1 addr=%h", j, bus.write_enable, bus.write_addr, wb + HW'(j) * ws);
      end
      @(negedge clk);
      for (int d = 0; d < dly; d++) begin
        @(negedge clk);
        checks++;
        if (bus.write_enable !== 1'b1 || bus.finish_write !== 1'b0) begin
          failures++;
          $display("FAIL wr_hold[%0d]: en=%b finish=%b expected 1 0", j, bus.write_enable, bus.finish_write);
        end
      end
      checks++;
      if (bus.write_data !== exp_wr(tag, kmode, j)) begin
        failures++;
        $display("FAIL wr_data[%0d]: got %h expected %h", j, bus.write_data, exp_wr(tag, kmode, j));
      end
      bus.write_ready = 1;
      @(negedge clk);
      bus.write_ready = 0;
      checks++;
      if (bus.finish_write !== 1'b1) begin
        failures++;
        $display("FAIL wr_ack[%0d]: finish=%b expected 1", j, bus.finish_write);
      end
      @(negedge clk);
    end
  endtask

  task automatic run_job(input int tag, input logic [HW-1:0] rb, wb, rs, ws, input int nr, nw,
                         input int rdly, wdly, kmode, input logic [DW-1:0] ret);
    int s_done, s_frd, s_aps, s_rden, s_wren;
    s_done = n_done; s_frd = n_frd; s_aps = n_aps; s_rden = n_rden; s_wren = n_wren;
    do_start(rb, wb, rs, ws, HW'(nr), HW'(nw));
    checks++;
    if (busy !== 1'b1 || error !== 1'b0) begin
      failures++;
      $display("FAIL job%0d_start: busy=%b error=%b expected 1 0", tag, busy, error);
    end
    do_reads(tag, rb, rs, nr, rdly);
    run_kernel(tag, kmode, nr, ret);
    do_writes(tag, kmode, wb, ws, nw, wdly);
    checks++;
    if (done !== 1'b1 || busy !== 1'b1 || bus.write_enable !== 1'b0) begin
      failures++;
      $display("FAIL job%0d_fin: done=%b busy=%b wr_en=%b expected 1 1 0", tag, done, busy, bus.write_enable);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL job%0d_idle: done=%b busy=%b expected 0 0", tag, done, busy);
    end
    checks++;
    if (n_done - s_done != 1 || n_aps - s_aps != 1 || n_frd - s_frd != nr) begin
      failures++;
      $display("FAIL job%0d_pulses: done=%0d ap_start=%0d finish_read=%0d expected 1 1 %0d",
               tag, n_done - s_done, n_aps - s_aps, n_frd - s_frd, nr);
    end
    checks++;
    if (n_rden - s_rden != nr * (2 + rdly) || n_wren - s_wren != nw * (3 + wdly)) begin
      failures++;
      $display("FAIL job%0d_enables: rd_en_cycles=%0d wr_en_cycles=%0d expected %0d %0d",
               tag, n_rden - s_rden, n_wren - s_wren, nr * (2 + rdly), nw * (3 + wdly));
    end
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1;
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 0 || done !== 0 || error !== 0 || returnvalue !== '0 || bus.read_enable !== 0 ||
        bus.write_enable !== 0 || bus.ap_start !== 0 || bus.buff_q0 !== '0 || bus.buff_q1 !== '0) begin
      failures++;
      $display("FAIL reset_state: busy=%b done=%b error=%b ret=%h rd_en=%b wr_en=%b ap_start=%b q0=%h q1=%h expected all 0",
               busy, done, error, returnvalue, bus.read_enable, bus.write_enable, bus.ap_start, bus.buff_q0, bus.buff_q1);
    end
    reset = 0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    run_job(1, 64'h100, 64'h800, 64'd4, 64'd4, 4, 4, 0, 0, 0, 32'd7);
  endtask

  task automatic test_slow_read();
    run_job(2, 64'h2000, 64'h3000, 64'd8, 64'd4, 4, 4, 3, 2, 2, 32'h55);
  endtask

  task automatic test_oversize();
    int s_done, s_rden, s_aps;
    s_done = n_done; s_rden = n_rden; s_aps = n_aps;
    do_start(64'h100, 64'h200, 64'd4, 64'd4, 64'd129, 64'd4);
    checks++;
    if (error !== 1'b1 || done !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL oversize_rd: error=%b done=%b busy=%b expected 1 1 0", error, done, busy);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || error !== 1'b1) begin
      failures++;
      $display("FAIL oversize_sticky: done=%b error=%b expected 0 1", done, error);
    end
    do_start(64'h100, 64'h200, 64'd4, 64'd4, 64'd4, 64'd129);
    checks++;
    if (error !== 1'b1 || done !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL oversize_wr: error=%b done=%b busy=%b expected 1 1 0", error, done, busy);
    end
    repeat (4) @(negedge clk);
    checks++;
    if (n_done - s_done != 2 || n_rden != s_rden || n_aps != s_aps) begin
      failures++;
      $display("FAIL oversize_activity: done_pulses=%0d rd_en_cycles=%0d ap_starts=%0d expected 2 0 0",
               n_done - s_done, n_rden - s_rden, n_aps - s_aps);
    end
    // Full-depth job from a wrapping base address also clears error.
    run_job(3, 64'hFFFF_FFFF_FFFF_FFF8, 64'h400, 64'd4, 64'd1, DEPTH, 2, 0, 0, 2, 32'h99);
  endtask

  task automatic test_collision();
    run_job(4, 64'h40, 64'h80, 64'd4, 64'd4, 8, 8, 0, 0, 1, 32'h123);
  endtask

  task automatic test_reset_kernel();
    int s_rden, s_aps;
    do_start(64'h500, 64'h600, 64'd4, 64'd4, 64'd2, 64'd2);
    do_reads(5, 64'h500, 64'd4, 2, 0);
    reset = 1;
    bus.buff_ce0 = 1; bus.buff_we0 = 1; bus.buff_address0 = '0; bus.buff_d0 = 32'hDEAD;
    @(negedge clk);
    checks++;
    if (busy !== 0 || done !== 0 || error !== 0 || returnvalue !== '0 || bus.read_enable !== 0 ||
        bus.write_enable !== 0 || bus.ap_start !== 0 || bus.finish_read !== 0 || bus.finish_write !== 0 ||
        bus.read_addr !== '0 || bus.write_addr !== '0 || bus.write_data !== '0 || bus.buff_q0 !== '0) begin
      failures++;
      $display("FAIL reset_kernel: busy=%b done=%b ret=%h rd_en=%b wr_en=%b ap_start=%b rd_addr=%h q0=%h expected all 0",
               busy, done, returnvalue, bus.read_enable, bus.write_enable, bus.ap_start, bus.read_addr, bus.buff_q0);
    end
    reset = 0;
    bus.buff_ce0 = 0; bus.buff_we0 = 0; bus.buff_d0 = '0;
    s_rden = n_rden; s_aps = n_aps;
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 0 || n_rden != s_rden || n_aps != s_aps) begin
      failures++;
      $display("FAIL reset_quiet: busy=%b rd_en_cycles=%0d ap_starts=%0d expected 0 0 0", busy, n_rden - s_rden, n_aps - s_aps);
    end
    run_job(6, 64'h700, 64'h900, 64'd4, 64'd4, 4, 4, 1, 0, 0, 32'h77);
  endtask

  task automatic test_back_to_back();
    run_job(7, 64'h10, 64'h90, 64'd4, 64'd4, 3, 3, 0, 0, 0, 32'h11);
    run_job(8, 64'h20, 64'h0, 64'd4, 64'd4, 2, 0, 0, 0, 0, 32'h22);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_slow_read();
    test_oversize();
    test_collision();
    test_reset_kernel();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
